aximm_burst_writer: RTL and testbench

// - AXI4 write master: drains a show-ahead FIFO into memory as INCR bursts; replaces inline burst logic in aximm_test tops.
// - Writes nSize bytes at pDstPxl, nTimes passes (each pass restarts at pDstPxl); ap_start/ap_done block-level control.
// - Bursts capped by MAX_BURST, never cross 4KB; up to MAX_OUTSTANDING bursts awaiting BRESP.

---
 rtl/aximm_pkg.sv | 17 +
 rtl/aximm_burst_len_calc.sv | 36 +++
 rtl/aximm_burst_writer.sv | 206 ++++++++++++++++++++
 tb/tb_aximm_burst_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aximm_pkg.sv
// Shared AXI4 constants and the burst-writer state encoding.
package aximm_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [12:0] AXI_4KB        = 13'd4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/aximm_burst_len_calc.sv
// Burst length: the smallest of beats left in the pass, MAX_BURST and
// the beats remaining before the next 4KB boundary.
module aximm_burst_len_calc
  import aximm_pkg::*;
#(
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned BYTES_PER_BEAT = 4
) (
  input  logic [11:0] addr_low,
  input  logic [31:0] remaining,
  output logic [8:0]  len
);

  localparam int unsigned BEAT_SHIFT = $clog2(BYTES_PER_BEAT);

  logic [12:0] room_bytes_s;
  logic [31:0] room_beats_s;
  logic [31:0] cap_s;

  // Minimum of the three limits; addr_low is already beat aligned.
  always_comb begin
    room_bytes_s = AXI_4KB - {1'b0, addr_low};
    room_beats_s = {19'd0, room_bytes_s >> BEAT_SHIFT};
    if (remaining < 32'(MAX_BURST)) begin
      cap_s = remaining;
    end else begin
      cap_s = 32'(MAX_BURST);
    end
    if (room_beats_s < cap_s) begin
      len = room_beats_s[8:0];
    end else begin
      len = cap_s[8:0];
    end
  end

endmodule

// File: rtl/aximm_burst_writer.sv
// AXI4 write master: streams a show-ahead FIFO to memory as INCR bursts,
// nTimes passes of nSize bytes at pDstPxl, with ap_* block-level control.
module aximm_burst_writer
  import aximm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_ready,
  output logic                    ap_done,
  output logic                    ap_idle,
  input  logic [ADDR_WIDTH-1:0]   pDstPxl,
  input  logic [31:0]             nSize,
  input  logic [31:0]             nTimes,
  output logic                    err,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_empty,
  output logic                    m_axi_mm_video_AWVALID,
  input  logic                    m_axi_mm_video_AWREADY,
  output logic [ADDR_WIDTH-1:0]   m_axi_mm_video_AWADDR,
  output logic [ID_WIDTH-1:0]     m_axi_mm_video_AWID,
  output logic [7:0]              m_axi_mm_video_AWLEN,
  output logic [2:0]              m_axi_mm_video_AWSIZE,
  output logic [1:0]              m_axi_mm_video_AWBURST,
  output logic                    m_axi_mm_video_WVALID,
  input  logic                    m_axi_mm_video_WREADY,
  output logic [DATA_WIDTH-1:0]   m_axi_mm_video_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_axi_mm_video_WSTRB,
  output logic                    m_axi_mm_video_WLAST,
  input  logic                    m_axi_mm_video_BVALID,
  output logic                    m_axi_mm_video_BREADY,
  input  logic [1:0]              m_axi_mm_video_BRESP
);

  localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int unsigned OUTS_W         = $clog2(MAX_OUTSTANDING + 1);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   base_addr_r, addr_r;
  logic [31:0]             beats_r, remaining_r, passes_r;
  logic [8:0]              burst_len_r, beat_cnt_r, calc_len_s;
  logic [OUTS_W-1:0]       outstanding_r;
  logic                    err_r, ap_done_r;
  logic [31:0]             start_beats_s;
  logic                    start_s, outs_full_s, aw_hs_s, w_hs_s, b_hs_s, last_beat_s;

  assign start_beats_s = nSize >> BEAT_SHIFT;
  assign start_s       = (state_r == ST_IDLE) && ap_start;
  assign outs_full_s   = (outstanding_r == OUTS_W'(MAX_OUTSTANDING));
  assign last_beat_s   = (beat_cnt_r == (burst_len_r - 9'd1));

  assign m_axi_mm_video_AWVALID = (state_r == ST_ADDR);
  assign m_axi_mm_video_AWADDR  = addr_r;
  assign m_axi_mm_video_AWID    = '0;
  assign m_axi_mm_video_AWLEN   = 8'(burst_len_r - 9'd1);
  assign m_axi_mm_video_AWSIZE  = 3'(BEAT_SHIFT);
  assign m_axi_mm_video_AWBURST = AXI_BURST_INCR;
  assign m_axi_mm_video_WVALID  = (state_r == ST_DATA) && !fifo_empty;
  assign m_axi_mm_video_WDATA   = fifo_rd_data;
  assign m_axi_mm_video_WSTRB   = '1;
  assign m_axi_mm_video_WLAST   = last_beat_s;
  assign m_axi_mm_video_BREADY  = (state_r != ST_IDLE);
  assign fifo_rd_en             = w_hs_s;
  assign ap_idle                = (state_r == ST_IDLE);
  assign ap_done                = ap_done_r;
  assign err                    = err_r;

  assign aw_hs_s = m_axi_mm_video_AWVALID && m_axi_mm_video_AWREADY;
  assign w_hs_s  = m_axi_mm_video_WVALID && m_axi_mm_video_WREADY;
  assign b_hs_s  = m_axi_mm_video_BVALID && m_axi_mm_video_BREADY;

  aximm_burst_len_calc #(
    .MAX_BURST      (MAX_BURST),
    .BYTES_PER_BEAT (BYTES_PER_BEAT)
  ) u_len_calc (
    .addr_low  (addr_r[11:0]),
    .remaining (remaining_r),
    .len       (calc_len_s)
  );

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and the ap_ready acknowledge.
  always_comb begin
    state_s  = state_r;
    ap_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ap_start) begin
          ap_ready = 1'b1;
          if (start_beats_s == 32'd0 || nTimes == 32'd0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CALC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (outs_full_s) begin
          state_s = ST_CALC;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_mm_video_AWREADY) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        // remaining_r already excludes the burst in flight
        if (w_hs_s && last_beat_s) begin
          if (remaining_r != 32'd0 || passes_r > 32'd1) begin
            state_s = ST_CALC;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Job parameters, address walk and per-burst beat counting.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      base_addr_r <= '0;
      addr_r      <= '0;
      beats_r     <= 32'd0;
      remaining_r <= 32'd0;
      passes_r    <= 32'd0;
      burst_len_r <= 9'd0;
      beat_cnt_r  <= 9'd0;
    end else if (start_s) begin
      base_addr_r <= pDstPxl & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
      addr_r      <= pDstPxl & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
      beats_r     <= start_beats_s;
      remaining_r <= start_beats_s;
      passes_r    <= nTimes;
    end else if (state_r == ST_CALC && !outs_full_s) begin
      burst_len_r <= calc_len_s;
    end else if (aw_hs_s) begin
      addr_r      <= addr_r + (ADDR_WIDTH'(burst_len_r) << BEAT_SHIFT);
      remaining_r <= remaining_r - {23'd0, burst_len_r};
      beat_cnt_r  <= 9'd0;
    end else if (w_hs_s) begin
      beat_cnt_r <= beat_cnt_r + 9'd1;
      if (last_beat_s && remaining_r == 32'd0 && passes_r > 32'd1) begin
        passes_r    <= passes_r - 32'd1;
        addr_r      <= base_addr_r;
        remaining_r <= beats_r;
      end
    end
  end

  // Outstanding-burst count, error flag and done pulse.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      outstanding_r <= '0;
      err_r         <= 1'b0;
      ap_done_r     <= 1'b0;
    end else begin
      ap_done_r <= (state_r == ST_DONE);
      if (aw_hs_s && !b_hs_s) begin
        outstanding_r <= outstanding_r + OUTS_W'(1);
      end else if (b_hs_s && !aw_hs_s && outstanding_r != '0) begin
        outstanding_r <= outstanding_r - OUTS_W'(1);
      end
      if (start_s) begin
        err_r <= 1'b0;
      end else if (b_hs_s && m_axi_mm_video_BRESP != AXI_RESP_OKAY) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aximm_burst_writer.sv
// Self-checking bench: reference burst model feeds scoreboard queues; a
// random AXI slave/FIFO drives the DUT and a monitor pops and compares.
module tb_aximm_burst_writer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n, ap_start, ap_ready, ap_done, ap_idle, err;
  logic [63:0] pDstPxl;
  logic [31:0] nSize, nTimes;
  logic        fifo_rd_en, fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [63:0] AWADDR;
  logic [0:0]  AWID;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, BRESP;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  typedef struct { int due; logic [1:0] resp; } b_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic        exp_done[$];
  logic [31:0] src_q[$];
  b_t          b_pend[$];
  int aw_rd = 0, w_rd = 0, done_rd = 0, src_rd = 0;
  int checks = 0, failures = 0;
  int done_cnt = 0, out_cnt = 0, max_out = 0, aw_total = 0, wl_total = 0;
  int cyc = 0, gburst = 0, bad_abs = -1, b_delay = 0;
  bit rnd_w = 0, rnd_aw = 0, mon_en = 0, flush_req = 0, b_taken = 0;

  aximm_burst_writer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .pDstPxl(pDstPxl), .nSize(nSize),
    .nTimes(nTimes), .err(err), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty),
    .m_axi_mm_video_AWVALID(AWVALID), .m_axi_mm_video_AWREADY(AWREADY),
    .m_axi_mm_video_AWADDR(AWADDR), .m_axi_mm_video_AWID(AWID),
    .m_axi_mm_video_AWLEN(AWLEN), .m_axi_mm_video_AWSIZE(AWSIZE),
    .m_axi_mm_video_AWBURST(AWBURST), .m_axi_mm_video_WVALID(WVALID),
    .m_axi_mm_video_WREADY(WREADY), .m_axi_mm_video_WDATA(WDATA),
    .m_axi_mm_video_WSTRB(WSTRB), .m_axi_mm_video_WLAST(WLAST),
    .m_axi_mm_video_BVALID(BVALID), .m_axi_mm_video_BREADY(BREADY),
    .m_axi_mm_video_BRESP(BRESP)
  );

  initial forever #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Slave and FIFO: inputs change only on the falling edge.
  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    fifo_empty = 1'b1; fifo_rd_data = 32'd0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (b_taken) begin BVALID = 1'b0; void'(b_pend.pop_front()); b_taken = 0; end
      if (flush_req) begin b_pend.delete(); BVALID = 1'b0; src_rd = src_q.size(); end
      AWREADY = rnd_aw ? ($urandom_range(0, 3) != 0) : 1'b1;
      WREADY  = rnd_w ? ($urandom_range(0, 3) != 0) : 1'b1;
      fifo_empty = (src_rd >= src_q.size()) || (rnd_w && $urandom_range(0, 3) == 0);
      fifo_rd_data = (src_rd < src_q.size()) ? src_q[src_rd] : 32'd0;
      if (!BVALID && b_pend.size() != 0 && b_pend[0].due <= cyc) begin
        BVALID = 1'b1;
        BRESP  = b_pend[0].resp;
      end
      #1;
      if (fifo_rd_en && src_rd < src_q.size()) src_rd++;
      if (WVALID && WREADY && WLAST) begin
        b_pend.push_back('{cyc + b_delay, (gburst == bad_abs) ? 2'b10 : 2'b00});
        gburst++;
      end
      b_taken = BVALID && BREADY;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake.
  initial begin
    aw_t a; w_t w; logic e; bit aw_stall = 0; logic [71:0] stall_v = '0;
    forever begin
      @(negedge ap_clk); #2;
      if (!mon_en) begin
        out_cnt = 0; aw_total = 0; wl_total = 0; aw_stall = 0;
        aw_rd = exp_aw.size(); w_rd = exp_w.size(); done_rd = exp_done.size();
      end else begin
        if (aw_stall) chk("aw_stable", {AWVALID, AWADDR, AWLEN}, {1'b1, stall_v});
        aw_stall = AWVALID && !AWREADY;
        stall_v  = {AWADDR, AWLEN};
        if (AWVALID && AWREADY) begin
          if (aw_rd >= exp_aw.size()) chk("aw_unexpected", {AWADDR, AWLEN}, 128'd0);
          else begin a = exp_aw[aw_rd]; aw_rd++; chk("aw_addr_len", {AWADDR, AWLEN}, {a.addr, a.len}); end
          chk("aw_const", {AWID, AWSIZE, AWBURST}, {1'b0, 3'd2, 2'b01});
          aw_total++; out_cnt++;
          if (out_cnt > max_out) max_out = out_cnt;
          chk("outstanding_le4", 1'(out_cnt <= 4), 1'b1);
        end
        if (WVALID || fifo_rd_en) chk("fifo_pop", fifo_rd_en, WVALID && WREADY);
        if (WVALID) chk("wvalid_nonempty", fifo_empty, 1'b0);
        if (WVALID && WREADY) begin
          chk("w_after_aw", 1'(aw_total > wl_total), 1'b1);
          if (w_rd >= exp_w.size()) chk("w_unexpected", {WDATA, WLAST}, 128'd0);
          else begin w = exp_w[w_rd]; w_rd++; chk("w_data_last", {WDATA, WLAST, WSTRB}, {w.data, w.last, 4'hF}); end
          if (WLAST) wl_total++;
        end
        if (BVALID && BREADY) out_cnt--;
        if (ap_done) begin
          if (done_rd >= exp_done.size()) chk("done_unexpected", ap_done, 1'b0);
          else begin e = exp_done[done_rd]; done_rd++; chk("done_err", err, e); end
          chk("done_after_bresp", out_cnt, 0);
          done_cnt++;
        end
      end
    end
  end

  // Reference model: derives bursts from the addressing rules, then starts the job.
  task automatic start_job(input logic [63:0] base, input int unsigned size,
                           input int unsigned times, input int bdel, input int bad,
                           input bit rw, input bit raw, output int d0);
    logic [63:0] a; int unsigned beats, r, room, l, nb; logic [31:0] word;
    rnd_w = rw; rnd_aw = raw; b_delay = bdel;
    bad_abs = (bad < 0) ? -1 : gburst + bad;
    beats = size / 4; nb = 0;
    for (int p = 0; p < int'(times) && beats != 0; p++) begin
      a = base & ~64'h3; r = beats;
      while (r > 0) begin
        room = (4096 - int'(a % 64'd4096)) / 4;
        l = (r > 16) ? 16 : r;
        if (l > room) l = room;
        exp_aw.push_back('{a, 8'(l - 1)});
        for (int b = 0; b < int'(l); b++) begin
          word = $urandom;
          src_q.push_back(word);
          exp_w.push_back('{word, 1'(b == int'(l) - 1)});
        end
        a += 64'(l * 4); r -= l; nb++;
      end
    end
    exp_done.push_back(bad >= 0 && bad < int'(nb));
    d0 = done_cnt;
    @(negedge ap_clk);
    pDstPxl = base; nSize = size; nTimes = times; ap_start = 1'b1;
    #3 chk("ap_ready_pulse", {ap_ready, ap_idle}, 2'b11);
    @(negedge ap_clk);
    ap_start = 1'b0; pDstPxl = {$urandom, $urandom}; nSize = $urandom; nTimes = $urandom;
    #3 chk("ap_ready_one_cycle", {ap_ready, ap_idle}, 2'b00);
    @(negedge ap_clk);
    #3;
    if (beats != 0 && times != 0) chk("awvalid_latency", AWVALID, 1'b1);
    else chk("zero_job_done_latency", ap_done, 1'b1);
  endtask

  task automatic wait_done(input int d0, input string nm);
    for (int i = 0; i < 6000 && done_cnt == d0; i++) @(negedge ap_clk);
    chk({nm, "_done_seen"}, 1'(done_cnt != d0), 1'b1);
    #3 chk({nm, "_all_consumed"}, {32'(exp_aw.size() - aw_rd), 32'(exp_w.size() - w_rd)}, 64'd0);
  endtask

  task automatic run_job(input logic [63:0] base, input int unsigned size,
                         input int unsigned times, input int bdel, input int bad,
                         input bit rw, input bit raw, input string nm);
    int d0;
    start_job(base, size, times, bdel, bad, rw, raw, d0);
    wait_done(d0, nm);
  endtask

  initial begin
    int d0, w0;
    ap_rst_n = 1'b0; ap_start = 1'b0; pDstPxl = 64'd0; nSize = 32'd0; nTimes = 32'd0;
    repeat (3) @(negedge ap_clk);
    #3 chk("reset_state", {AWVALID, WVALID, fifo_rd_en, BREADY, ap_ready, ap_done, err, ap_idle}, 8'b0000_0001);
    @(negedge ap_clk);
    ap_rst_n = 1'b1; mon_en = 1;

    run_job(64'h1000, 64,  1, 0, -1, 0, 0, "single_burst");
    run_job(64'h1000, 100, 1, 0, -1, 0, 0, "two_bursts");
    run_job(64'h0FF0, 64,  1, 0, -1, 0, 0, "split_4kb");
    run_job(64'h1000, 16,  3, 0, -1, 0, 0, "three_passes");
    run_job(64'h1000, 0,   1, 0, -1, 0, 0, "zero_size");
    run_job(64'h1000, 64,  0, 0, -1, 0, 0, "zero_times");
    run_job(64'h1003, 40,  1, 0, -1, 1, 1, "unaligned_base");
    run_job(64'h2000, 4,  10, 20, 1, 1, 0, "stall_bresp_err");
    chk("stall_max_outstanding", max_out, 4);
    for (int k = 0; k < 5; k++)
      run_job(64'h0F00 + 64'($urandom_range(0, 511)), $urandom_range(0, 300),
              $urandom_range(1, 3), $urandom_range(0, 6), $urandom_range(0, 3) == 0 ? 0 : -1,
              1, 1, "random_job");

    start_job(64'h3000, 256, 1, 0, -1, 0, 0, d0);
    w0 = w_rd;
    for (int i = 0; i < 500 && w_rd < w0 + 5; i++) @(negedge ap_clk);
    chk("mid_burst_reached", 1'(w_rd >= w0 + 5), 1'b1);
    @(negedge ap_clk);
    mon_en = 0; flush_req = 1; ap_rst_n = 1'b0;
    @(negedge ap_clk);
    #3 chk("reset_mid_burst", {AWVALID, WVALID, fifo_rd_en, BREADY, ap_ready, ap_done, err, ap_idle}, 8'b0000_0001);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    flush_req = 0; mon_en = 1;
    @(negedge ap_clk);
    run_job(64'h1000, 64, 1, 0, -1, 0, 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
